mem_responder: RTL and testbench

- Backing-memory responder for the cache's memory port.
- Accepts single-word read/write requests issued by the cache controller on mem_ren/mem_wen/mem_addr/mem_din.
- Services each request from an internal word array after a fixed, parameterised latency.
- Returns read data on mem_dout with a one-cycle mem_rdy completion pulse. Used as main-memory stand-in under cache_top in simulation and FPGA bring-up.

---
 rtl/mem_responder.sv | 191 +++++++++++++++++++
 tb/tb_mem_responder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: backing-memory stand-in for the cache memory port.
// Single-word read/write requests are serviced from an internal word array
// after a fixed LATENCY (1..255) and completed with a one-cycle mem_rdy pulse.
// Optional build macro MEM_RANGE_CHECK_EN adds the mem_err output and makes
// addresses above the array range fault instead of aliasing.
//
// Handshake: in IDLE, any clock edge that sees mem_ren or mem_wen high accepts
// a request; the initiator keeps the request asserted until it samples
// mem_rdy=1 and then deasserts it. A request still high in the IDLE cycle
// after RESP is taken as a new request. While busy, request inputs are ignored.
module mem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_din,
  output logic [31:0] mem_dout,
  output logic        mem_rdy,
  output logic        mem_busy,
`ifdef MEM_RANGE_CHECK_EN
  output logic        mem_err,
`endif
  output logic [1:0]  dbg_state
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  // Counter preload on accept; unused when LATENCY==1 (RESP entered directly).
  localparam logic [7:0] CNT_INIT = (LATENCY >= 2) ? 8'(LATENCY - 2) : 8'd0;
  localparam bit         SINGLE   = (LATENCY == 1);

  localparam logic [31:0] OOR_DATA = 32'hDEAD_BEEF;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [7:0]        cnt;
  logic [7:0]        cnt_nxt;

  // Request captured at accept time.
  logic [ADDR_W-1:0] lat_idx;
  logic [31:0]       lat_data;
  logic              lat_wr;
  logic              lat_oor;

  logic [31:0]       mem [DEPTH];

  logic              req;
  logic              accept;
  logic              go_resp;
  logic [ADDR_W-1:0] in_idx;
  logic              in_oor;

  // Request as seen on the edge that enters RESP: straight from the inputs
  // when entering from IDLE (LATENCY==1), from the latch otherwise.
  logic [ADDR_W-1:0] rsp_idx;
  logic [31:0]       rsp_data;
  logic              rsp_wr;
  logic              rsp_oor;

  logic              commit_wr;
  logic              commit_rd;

  assign req    = mem_ren | mem_wen;
  assign accept = (state == IDLE) && req;
  assign in_idx = mem_addr[ADDR_W+1:2];

`ifdef MEM_RANGE_CHECK_EN
  assign in_oor = |mem_addr[31:ADDR_W+2];

  logic unused_addr;
  assign unused_addr = ^mem_addr[1:0];
`else
  // Upper address bits alias modulo the array depth.
  assign in_oor = 1'b0;

  logic unused_addr;
  assign unused_addr = ^{mem_addr[31:ADDR_W+2], mem_addr[1:0]};
`endif

  // Next-state and latency-counter logic.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (req) begin
          if (SINGLE) begin
            state_nxt = RESP;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 8'd0) begin
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 8'd0;
      end
    endcase
  end

  // Select the request that completes on this edge.
  always_comb begin
    if (state == IDLE) begin
      rsp_idx  = in_idx;
      rsp_data = mem_din;
      rsp_wr   = mem_wen;
      rsp_oor  = in_oor;
    end else begin
      rsp_idx  = lat_idx;
      rsp_data = lat_data;
      rsp_wr   = lat_wr;
      rsp_oor  = lat_oor;
    end
  end

  assign go_resp   = (state_nxt == RESP) && (state != RESP);
  // The !rst term keeps a write from landing if reset and the RESP edge coincide.
  assign commit_wr = go_resp && rsp_wr && !rsp_oor && !rst;
  assign commit_rd = go_resp && !rsp_wr;

  // FSM state and latency counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Capture the accepted request; later input changes cannot disturb it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_idx  <= '0;
      lat_data <= 32'd0;
      lat_wr   <= 1'b0;
      lat_oor  <= 1'b0;
    end else if (accept) begin
      lat_idx  <= in_idx;
      lat_data <= mem_din;
      lat_wr   <= mem_wen;
      lat_oor  <= in_oor;
    end
  end

  // Read data register: updated only by a read completion or reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_dout <= 32'd0;
    end else if (commit_rd) begin
      mem_dout <= rsp_oor ? OOR_DATA : mem[rsp_idx];
    end
  end

  // Word array: never reset, so contents survive rst.
  always_ff @(posedge clk) begin
    if (commit_wr) begin
      mem[rsp_idx] <= rsp_data;
    end
  end

  // Status outputs decoded from registered state only.
  assign mem_rdy   = (state == RESP);
  assign mem_busy  = (state != IDLE);
  assign dbg_state = state;

`ifdef MEM_RANGE_CHECK_EN
  assign mem_err = (state == RESP) && lat_oor;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder: a LATENCY=4 instance for the main sequence and a
// LATENCY=1 instance for the back-to-back case. Expected read data comes from a
// bench-side word model and is queued when a read is driven.
module tb_mem_responder;

  localparam int ADDR_W = 10;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  // LATENCY=4 instance
  logic        ren, wen;
  logic [31:0] addr, din, dout;
  logic        rdy, busy, err;
  logic [1:0]  st;

  // LATENCY=1 instance
  logic        ren1, wen1;
  logic [31:0] addr1, din1, dout1;
  logic        rdy1, busy1, err1;
  logic [1:0]  st1;

  mem_responder #(.ADDR_W(ADDR_W), .LATENCY(4)) u_dut (
    .clk(clk), .rst(rst), .mem_ren(ren), .mem_wen(wen), .mem_addr(addr),
    .mem_din(din), .mem_dout(dout), .mem_rdy(rdy), .mem_busy(busy),
`ifdef MEM_RANGE_CHECK_EN
    .mem_err(err),
`endif
    .dbg_state(st)
  );

  mem_responder #(.ADDR_W(ADDR_W), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .mem_ren(ren1), .mem_wen(wen1), .mem_addr(addr1),
    .mem_din(din1), .mem_dout(dout1), .mem_rdy(rdy1), .mem_busy(busy1),
`ifdef MEM_RANGE_CHECK_EN
    .mem_err(err1),
`endif
    .dbg_state(st1)
  );

`ifndef MEM_RANGE_CHECK_EN
  assign err  = 1'b0;
  assign err1 = 1'b0;
`endif

  logic [31:0] model  [1 << ADDR_W];
  logic [31:0] model1 [1 << ADDR_W];
  logic [31:0] exp_q[$];
  logic [31:0] exp_dout;
  logic [31:0] exp_dout1;
  int          n_pass;
  int          n_total;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'(a[ADDR_W+1:2]);
  endfunction

  function automatic bit oor(input logic [31:0] a);
`ifdef MEM_RANGE_CHECK_EN
    return |a[31:ADDR_W+2];
`else
    return 1'b0;
`endif
  endfunction

  // One request on the LATENCY=4 instance. a_late replaces the address after
  // the accept edge (and din is inverted) to show the latched request is used.
  task automatic op4(input logic r, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] a_late);
    int          cyc;
    logic [31:0] got;
    bit          range;
    range = oor(a);
    @(negedge clk);
    ren = r; wen = w; addr = a; din = d;
    if (w) begin
      if (!range) model[widx(a)] = d;
    end else begin
      exp_q.push_back(range ? 32'hDEAD_BEEF : model[widx(a)]);
    end
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        addr = a_late;
        din  = ~d;
      end
      chk("busy_active", {31'd0, busy}, 32'd1);
    end while (!rdy && cyc < 300);
    chk("latency", cyc, 32'd4);
    ren = 1'b0; wen = 1'b0;
    if (w) begin
      chk("dout_hold_on_write", dout, exp_dout);
    end else if (exp_q.size() > 0) begin
      got      = exp_q.pop_front();
      exp_dout = got;
      chk("read_data", dout, got);
    end
`ifdef MEM_RANGE_CHECK_EN
    chk("mem_err", {31'd0, err}, {31'd0, range});
`endif
    @(negedge clk);
    chk("rdy_one_cycle", {31'd0, rdy}, 32'd0);
    chk("busy_idle", {31'd0, busy}, 32'd0);
  endtask

  // Single write on the LATENCY=1 instance.
  task automatic op1_wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    wen1 = 1'b1; addr1 = a; din1 = d;
    model1[widx(a)] = d;
    @(negedge clk);
    chk("l1_wr_rdy", {31'd0, rdy1}, 32'd1);
    chk("l1_wr_dout_hold", dout1, exp_dout1);
    wen1 = 1'b0;
    @(negedge clk);
    chk("l1_wr_rdy_low", {31'd0, rdy1}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] got;
    n_pass = 0; n_total = 0;
    exp_dout = 32'd0; exp_dout1 = 32'd0;
    rst = 1'b1;
    ren = 0; wen = 0; addr = 0; din = 0;
    ren1 = 0; wen1 = 0; addr1 = 0; din1 = 0;
    repeat (2) @(negedge clk);
    chk("reset_rdy", {31'd0, rdy}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_dout", dout, 32'd0);
    chk("reset_state", {30'd0, st}, 32'd0);
    chk("reset_dout1", dout1, 32'd0);
    chk("reset_rdy1", {31'd0, rdy1}, 32'd0);
    rst = 1'b0;

    // Write then read back
    op4(1'b0, 1'b1, 32'h10, 32'hA5A5_0001, 32'h10);
    op4(1'b1, 1'b0, 32'h10, 32'h0, 32'h10);

    // Simultaneous ren+wen behaves as a write and leaves mem_dout alone
    op4(1'b0, 1'b1, 32'hC, 32'h1234_5678, 32'hC);
    op4(1'b1, 1'b0, 32'hC, 32'h0, 32'hC);
    op4(1'b1, 1'b1, 32'h8, 32'h5555_AAAA, 32'h8);
    op4(1'b1, 1'b0, 32'h8, 32'h0, 32'h8);

    // Reset during WAIT discards the write
    op4(1'b0, 1'b1, 32'h20, 32'h0000_0007, 32'h20);
    @(negedge clk);
    wen = 1'b1; addr = 32'h20; din = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("mid_wr_busy", {31'd0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_rdy", {31'd0, rdy}, 32'd0);
    chk("rst_mid_dout", dout, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    exp_dout = 32'd0;
    @(negedge clk);
    wen = 1'b0; rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rst_no_rdy", {31'd0, rdy}, 32'd0);
    end
    op4(1'b1, 1'b0, 32'h20, 32'h0, 32'h20);

    // Address change during WAIT has no effect
    op4(1'b0, 1'b1, 32'h40, 32'h4040_4040, 32'h40);
    op4(1'b0, 1'b1, 32'h44, 32'h4444_4444, 32'h44);
    op4(1'b1, 1'b0, 32'h40, 32'h0, 32'h44);

    // Out-of-range addresses: alias to low words, or fault with the macro
    op4(1'b0, 1'b1, 32'h0, 32'hCAFE_0000, 32'h0);
    op4(1'b0, 1'b1, 32'h4, 32'hCAFE_0004, 32'h4);
    op4(1'b1, 1'b0, 32'h0000_1000, 32'h0, 32'h0000_1000);
    op4(1'b0, 1'b1, 32'h0000_1004, 32'h0BAD_0BAD, 32'h0000_1004);
    op4(1'b1, 1'b0, 32'h4, 32'h0, 32'h4);

    // Random mix over a small window, fully written first
    for (int i = 0; i < 16; i++) begin
      a = 32'(i) << 2;
      op4(1'b0, 1'b1, a, $urandom, a);
    end
    for (int i = 0; i < 12; i++) begin
      a = 32'($urandom_range(0, 15)) << 2;
      if ($urandom_range(0, 1) == 1) op4(1'b0, 1'b1, a, $urandom, a);
      else                           op4(1'b1, 1'b0, a, 32'h0, a);
    end

    // LATENCY=1: back-to-back reads with ren held
    op1_wr(32'h0, 32'h11);
    op1_wr(32'h4, 32'h22);
    @(negedge clk);
    ren1 = 1'b1; addr1 = 32'h0;
    exp_q.push_back(model1[0]);
    @(negedge clk);
    chk("l1_b2b_rdy0", {31'd0, rdy1}, 32'd1);
    got = exp_q.pop_front();
    chk("l1_b2b_data0", dout1, got);
    addr1 = 32'h4;
    exp_q.push_back(model1[1]);
    @(negedge clk);
    chk("l1_b2b_gap", {31'd0, rdy1}, 32'd0);
    @(negedge clk);
    chk("l1_b2b_rdy1", {31'd0, rdy1}, 32'd1);
    got = exp_q.pop_front();
    chk("l1_b2b_data1", dout1, got);
    ren1 = 1'b0;
    @(negedge clk);
    chk("l1_end_rdy", {31'd0, rdy1}, 32'd0);
    chk("l1_end_busy", {31'd0, busy1}, 32'd0);
    chk("l1_end_err", {31'd0, err1}, 32'd0);

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
